// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: frame-sequencer state encoding,
// default frame geometry and the bit index that marks the start bit.
package uart_rx_pkg;

    localparam int UART_DATA_WIDTH  = 8;
    localparam int UART_PRESC_WIDTH = 6;

    // The counter's bit_cnt is 0 during the start bit; data bits follow at 1..DATA_WIDTH.
    localparam int START_BIT_IDX = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_rx_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: walks START/DATA/PARITY/STOP on the shared edge/bit
// counter, gates the sampler, deserializer and checkers, and flags frame results.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int PRESC_WIDTH = UART_PRESC_WIDTH
) (
    input  logic                   CLK_FSM,
    input  logic                   RST_FSM,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic [PRESC_WIDTH-1:0] prescale,
    input  logic [PRESC_WIDTH-1:0] edge_cnt,
    input  logic [PRESC_WIDTH-1:0] bit_cnt,
    input  logic                   strt_glitch,
    input  logic                   par_err,
    input  logic                   stp_err,
    output logic                   cnt_en,
    output logic                   samp_en,
    output logic                   deser_en,
    output logic                   strt_chk_en,
    output logic                   par_chk_en,
    output logic                   stp_chk_en,
    output logic                   data_valid,
    output logic                   par_error,
    output logic                   stop_error,
    output logic                   busy,
    output logic [2:0]             o_dbg_state
);

    uart_rx_state_e r_state;
    uart_rx_state_e w_next_state;

    logic [PRESC_WIDTH-1:0] w_presc_m1;
    logic                   w_eob;
    logic                   w_last_data_bit;
    logic                   r_par_error;
    logic                   r_stop_error;

    assign w_presc_m1      = prescale - PRESC_WIDTH'(1);
    assign w_eob           = (edge_cnt == w_presc_m1);
    assign w_last_data_bit = (bit_cnt == PRESC_WIDTH'(START_BIT_IDX + DATA_WIDTH));

    always_ff @(posedge CLK_FSM) begin
        if (!RST_FSM) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Error flags are registered so they land in the first IDLE cycle after the failing EOB.
    always_ff @(posedge CLK_FSM) begin
        if (!RST_FSM) begin
            r_par_error  <= 1'b0;
            r_stop_error <= 1'b0;
        end else begin
            r_par_error  <= (r_state == ST_PARITY) && w_eob && par_err;
            r_stop_error <= (r_state == ST_STOP) && w_eob && stp_err;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!RX_IN) w_next_state = ST_START;
            end
            ST_START: begin
                if (w_eob) w_next_state = strt_glitch ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_eob && w_last_data_bit) w_next_state = PAR_EN ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_eob) w_next_state = par_err ? ST_IDLE : ST_STOP;
            end
            ST_STOP: begin
                if (w_eob) w_next_state = stp_err ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                // A low line here is the next frame's start bit, one cycle late.
                w_next_state = RX_IN ? ST_IDLE : ST_START;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_en      = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
        case (r_state)
            ST_START: begin
                cnt_en      = 1'b1;
                strt_chk_en = 1'b1;
            end
            ST_DATA: begin
                cnt_en = 1'b1;
            end
            ST_PARITY: begin
                cnt_en     = 1'b1;
                par_chk_en = 1'b1;
            end
            ST_STOP: begin
                cnt_en     = 1'b1;
                stp_chk_en = 1'b1;
            end
            ST_DONE: begin
                data_valid = 1'b1;
            end
            default: begin
                cnt_en = 1'b0;
            end
        endcase
    end

    assign samp_en     = cnt_en;
    assign deser_en    = (r_state == ST_DATA) && w_eob;
    assign par_error   = r_par_error;
    assign stop_error  = r_stop_error;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule : uart_rx_fsm
